// File: rtl/fifo_wptr_full.sv
// Write-side pointer, synchroniser and status flags for the async FIFO.
// Binary pointer addresses memory; Gray pointer crosses to the read side.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  wovf
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] level;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] wcount_q, wcount_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;

    always_comb begin
        wen     = winc & ~wfull_q;
        wbin_d  = wbin_q + PW'(wen);
        wgray_d = (wbin_d >> 1) ^ wbin_d;

        rbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(rq2_q >> i);
        end

        // Full when the write pointer is exactly one lap ahead of the read pointer
        full_cmp = {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]};
        level    = wbin_d - rbin_sync;

        wfull_d  = (wgray_d == full_cmp);
        wcount_d = level;
        wafull_d = (level >= PW'(AFULL_THRESH));
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rq1_q    <= '0;
            rq2_q    <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wcount_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rq1_q    <= rptr_gray;
            rq2_q    <= rq1_q;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wcount_q <= wcount_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wcount       = wcount_q;
    assign wovf         = wovf_q;
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, in the write clock domain, directly upstream of the dual-port FIFO memory.
- Converts the producer's write requests into the memory's write address and write enable.
- Keeps a binary and a Gray-coded write pointer.
- Synchronises the read domain's Gray pointer into the write domain.
- Produces full, almost-full, fill-level and sticky overflow status.

Parameters:
ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
wclk  input  1  write-domain clock; all state updates on rising edge.
wrst  input  1  synchronous, active-high reset.
winc  input  1  producer write request for this cycle.
rptr_gray  input  ADDR_WIDTH+1  read pointer in Gray code, asynchronous to wclk.
waddr  output  ADDR_WIDTH  write address to the FIFO memory (low bits of binary write pointer).
wen  output  1  write enable to the FIFO memory.
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wcount  output  ADDR_WIDTH+1  registered fill level as seen from the write domain (0..2**ADDR_WIDTH).
wovf  output  1  sticky overflow flag.

Behaviour:
- Reset (wrst=1 at a rising edge): the following all clear to 0 regardless of winc:
  - wbin, wptr_gray
  - sync stages rq1, rq2
  - wfull, walmost_full, wcount, wovf
  - waddr therefore reads 0.
  - Reset mid-operation discards all state; the read side must be reset in the same window.
- Synchroniser: two flops, rq1 <= rptr_gray, rq2 <= rq1, every edge.
  - Only rq2 is used for logic.
  - Latency from a rptr_gray change to rq2 is 2 edges.
- Write accept:
  - wen = winc & ~wfull, combinational from the registered wfull.
  - waddr = wbin[ADDR_WIDTH-1:0], combinational.
  - Memory captures the data on the same edge at which wbin advances.
- Pointer update:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1); wraps naturally.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both pointers are registered each edge.
- Full:
  - full_next = (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
  - wfull <= full_next.
  - wfull asserts on the same edge as the write that fills the FIFO.
  - wfull deasserts on the 3rd edge after rptr_gray advances (2 sync edges + 1 register edge). This pessimism is intended.
- Fill level:
  - rbin_sync = Gray-to-binary of rq2 (bit i = XOR of rq2[MSB:i]).
  - wcount <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1).
  - Never exceeds 2**ADDR_WIDTH while the read side is legal.
- Almost full: walmost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH.
- Overflow:
  - wovf <= 1 when winc & wfull at an edge.
  - Once set, it holds until reset.
  - A rejected write never changes wbin or the memory.
- Simultaneous events: a write and a read-pointer advance in the same cycle both take effect. Full is evaluated against rq2 (the stale read pointer), so it can assert for one write then clear 3 edges later.
- Outputs are glitch-free registers except wen and waddr. wptr_gray changes by at most one bit per edge, which the read-side synchroniser requires.

Test Plan:
1. Defaults, rptr_gray=0: assert wrst for 2 edges, then release.
   -> All outputs 0; wen=winc.
2. winc=1 for 8 consecutive edges, rptr_gray=0.
   -> waddr steps 0..7.
   -> wptr_gray goes 1,3,2,6,7,5,4,12.
   -> walmost_full=1 after the 6th write; wcount=8 and wfull=1 after the 8th.
3. From full, hold winc=1 one more edge.
   -> wen=0; wbin and wptr_gray unchanged (12).
   -> wovf=1 and stays 1 after winc drops, until wrst.
4. From full, set rptr_gray=1 (read pointer 1).
   -> wfull=1 through edges 1-2; wfull=0 and wcount=7 at edge 3.
   -> wen=1 on the next winc; wfull=1 again after that write.
5. Wrap-around: stream 20 writes while rptr_gray tracks wptr_gray delayed by 2 entries.
   -> wbin wraps 15->0; wptr_gray after 16 writes = 0.
   -> wfull never asserts; wovf stays 0.
6. Reset mid-operation: after 5 writes (wcount=5), pulse wrst for 1 edge with winc=1.
   -> All outputs 0 after the edge; the write in that cycle is dropped.
   -> Next write uses waddr=0.
